// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// =============================================================================
// instr_fetch_unit_if : imem req/gnt/rvalid bus plus the IF->ID valid/ready
//                       and redirect signals, bundled for the fetch unit.
// Rev 1.0
// =============================================================================
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc4,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc4,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// =============================================================================
// instr_fetch_unit : PC, single-outstanding imem fetch and a small fetch buffer
//                    feeding {instr, pc+4} to ID; flushes on redirect.
// Rev 1.0
// =============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus_io
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DROP  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [31:0]      fifo_instr_q [DEPTH];
   logic [31:0]      fifo_pc4_q   [DEPTH];

   logic req, valid, issue, push, pop, redirect;

   assign redirect = bus_io.redirect_valid;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state logic: a request issued under a redirect belongs to the old path
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: if (issue)              state_d = redirect ? S_DROP : S_WAIT;
         S_WAIT : if (bus_io.imem_rvalid) state_d = S_FETCH;
                  else if (redirect)      state_d = S_DROP;
         S_DROP : if (bus_io.imem_rvalid) state_d = S_FETCH;
         default:                         state_d = S_FETCH;
      endcase
   end

   // Output logic
   always_comb begin
      req   = rst_n && (state_q == S_FETCH) && (cnt_q < FULL_CNT);
      valid = rst_n && (cnt_q != '0) && !redirect;
      issue = req && bus_io.imem_gnt;
      pop   = valid && bus_io.id_ready;
      push  = rst_n && (state_q == S_WAIT) && bus_io.imem_rvalid && !redirect;
   end

   assign bus_io.imem_req  = req;
   assign bus_io.imem_addr = rst_n ? pc_q : 32'd0;
   assign bus_io.if_valid  = valid;
   assign bus_io.if_instr  = (rst_n && cnt_q != '0) ? fifo_instr_q[head_q] : 32'd0;
   assign bus_io.if_pc4    = (rst_n && cnt_q != '0) ? fifo_pc4_q[head_q]   : 32'd0;

   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      cnt_d    = cnt_q;
      head_d   = head_q;
      tail_d   = tail_q;
      if (redirect) begin
         pc_d   = bus_io.redirect_pc & 32'hFFFF_FFFC;
         cnt_d  = '0;
         head_d = '0;
         tail_d = '0;
      end else begin
         if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
         end
         if (push) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
         if (pop)  head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= PC_RESET;
         req_pc_q <= PC_RESET;
         cnt_q    <= '0;
         head_q   <= '0;
         tail_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[tail_q] <= bus_io.imem_rdata;
         fifo_pc4_q[tail_q]   <= req_pc_q + 32'd4;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// =============================================================================
// tb_instr_fetch_unit : random imem/ID/redirect stimulus against a queue-based
//                       reference model of the fetch unit.
// Rev 1.0
// =============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] PC_RST = 32'h0000_0400;
   localparam int          DEPTH  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .PC_RESET (PC_RST),
      .DEPTH    (DEPTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: architectural PC, outstanding-response kind, buffer queue
   logic [31:0] m_pc;
   logic [31:0] m_req_pc;
   int          m_owe;          // 0 none, 1 keep, 2 discard
   logic [63:0] m_q [$];        // {instr, pc4}

   // Memory responder
   bit          pend;
   int          lat;
   logic [31:0] p_addr;

   logic [31:0] iss_log [$];
   logic [31:0] pop_log [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic model_reset();
      m_pc     = PC_RST;
      m_req_pc = PC_RST;
      m_owe    = 0;
      m_q.delete();
      pend     = 0;
   endtask

   task automatic cycle(input logic rst, input int p_gnt, input int p_rdy,
                        input int p_redir, input int max_lat);
      logic        e_req, e_vld, issue, rv;
      logic [31:0] e_instr, e_pc4, rpc;
      @(negedge clk);
      rst_n = rst;
      bus.imem_gnt = ($urandom_range(99) < p_gnt);
      if (pend && rst) begin
         lat--;
         bus.imem_rvalid = (lat == 0);
      end else begin
         bus.imem_rvalid = rst && ($urandom_range(15) == 0);
      end
      bus.imem_rdata = (bus.imem_rvalid && pend) ? mem_word(p_addr) : $urandom();
      bus.id_ready = ($urandom_range(99) < p_rdy);
      bus.redirect_valid = rst && ($urandom_range(99) < p_redir);
      case ($urandom_range(3))
         0:       rpc = 32'h0000_1003;
         1:       rpc = 32'hFFFF_FFFC;
         2:       rpc = 32'hFFFF_FFF9;
         default: rpc = $urandom();
      endcase
      bus.redirect_pc = rpc;
      #1;
      e_req   = rst && (m_owe == 0) && (m_q.size() < DEPTH);
      e_vld   = rst && (m_q.size() != 0) && !bus.redirect_valid;
      e_instr = (rst && m_q.size() != 0) ? m_q[0][63:32] : 32'd0;
      e_pc4   = (rst && m_q.size() != 0) ? m_q[0][31:0]  : 32'd0;
      check("imem_req", 32'(bus.imem_req), 32'(e_req));
      if (e_req || !rst) check("imem_addr", bus.imem_addr, rst ? m_pc : 32'd0);
      check("if_valid", 32'(bus.if_valid), 32'(e_vld));
      check("if_instr", bus.if_instr, e_instr);
      check("if_pc4", bus.if_pc4, e_pc4);
      if (e_vld) check("instr_vs_pc4", bus.if_instr, mem_word(bus.if_pc4 - 32'd4));

      rv    = bus.imem_rvalid;
      issue = e_req && bus.imem_gnt;
      if (!rst) begin
         model_reset();
         iss_log.delete();
         pop_log.delete();
      end else begin
         if (issue) iss_log.push_back(m_pc);
         if (bus.redirect_valid) begin
            m_q.delete();
            if (m_owe == 0) m_owe = issue ? 2 : 0;
            else            m_owe = rv ? 0 : 2;
            m_pc = rpc & 32'hFFFF_FFFC;
         end else begin
            if (e_vld && bus.id_ready) begin
               pop_log.push_back(m_q[0][31:0]);
               void'(m_q.pop_front());
            end
            if (m_owe != 0 && rv) begin
               if (m_owe == 1) m_q.push_back({bus.imem_rdata, m_req_pc + 32'd4});
               m_owe = 0;
            end else if (issue) begin
               m_req_pc = m_pc;
               m_pc     = m_pc + 32'd4;
               m_owe    = 1;
            end
         end
         if (pend && rv) pend = 0;
         if (issue) begin
            pend   = 1;
            lat    = $urandom_range(max_lat, 1);
            p_addr = iss_log[$];
         end
      end
   endtask

   initial begin
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = 32'd0;
      bus.id_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      model_reset();

      repeat (3) cycle(1'b0, 100, 100, 0, 1);
      // Ideal memory and ID: sequential fetch from PC_RESET, one instr per 2 cycles
      repeat (20) cycle(1'b1, 100, 100, 0, 1);
      check("n_issued", 32'(iss_log.size() >= 3), 32'd1);
      check("n_popped", 32'(pop_log.size() >= 3), 32'd1);
      if (iss_log.size() >= 3 && pop_log.size() >= 3) begin
         check("addr0", iss_log[0], 32'h400);
         check("addr1", iss_log[1], 32'h404);
         check("addr2", iss_log[2], 32'h408);
         check("pc4_0", pop_log[0], 32'h404);
         check("pc4_1", pop_log[1], 32'h408);
         check("pc4_2", pop_log[2], 32'h40C);
      end
      check("pop_rate", 32'(pop_log.size()), 32'd9);

      // ID stall fills the buffer, then drains
      repeat (12) cycle(1'b1, 100, 0, 0, 1);
      repeat (10) cycle(1'b1, 100, 100, 0, 1);

      // Random traffic with redirects
      repeat (400) cycle(1'b1, 60, 60, 8, 4);
      // Reset in the middle of traffic, then continue
      repeat (2) cycle(1'b0, 60, 60, 0, 4);
      repeat (200) cycle(1'b1, 60, 40, 10, 3);
      repeat (300) cycle(1'b1, 80, 30, 30, 2);
      repeat (300) cycle(1'b1, 50, 80, 5, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
